// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Control unit for the multicycle 8-bit data / 16-bit instruction CPU.
// Each instruction is stepped through FETCH / DECODE / EXEC / MEM / WB.
// Every datapath control signal is decoded combinationally from the current
// state and the opcode latched in DECODE. The controller also makes the
// branch decision (pcsrc = branch & zero) so the datapath needs no branch
// logic of its own.
//
// Build option:
//   CTRL_TRAP_EN  defined   : an undefined opcode sends the FSM to TRAP, a
//                             terminal state that drives illegal=1.
//                 undefined : an undefined opcode retires as a NOP (PC+2
//                             from DECODE); illegal is constant 0.
//
// Ports:
//   clk         in   rising-edge system clock
//   reset       in   synchronous, active-high reset
//   instr[15:0] in   instruction register (valid from DECODE onward)
//   zero        in   ALU zero flag
//   mem_ready   in   memory completes the current access this cycle
//   mem_req     out  memory access request
//   mem_we      out  write access (store)
//   mem_iord    out  address select: 0 = pc, 1 = aluout
//   irwrite     out  load instruction register from readdata
//   pcen        out  PC write enable (one pulse per retired instruction)
//   pcsrc       out  select branch target
//   jump        out  select jump target
//   memtoreg    out  writeback selects readdata
//   alusrc      out  ALU B selects sign-extended immediate
//   regdst      out  destination register is instr[7:6]
//   regwrite    out  register file write enable
//   alucontrol  out  ALU operation
//   halted      out  HALT executed
//   illegal     out  undefined opcode trapped
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter int OPW = 4,
  parameter int FW  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_iord,
  output logic        irwrite,
  output logic        pcen,
  output logic        pcsrc,
  output logic        jump,
  output logic        memtoreg,
  output logic        alusrc,
  output logic        regdst,
  output logic        regwrite,
  output logic [2:0]  alucontrol,
  output logic        halted,
  output logic        illegal
);

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_SW    = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(4'b0011);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(4'b0100);
  localparam logic [OPW-1:0] OP_J     = OPW'(4'b0101);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(4'b1111);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_TRAP
  } state_t;

  state_t         state_reg;
  logic [OPW-1:0] opcode_reg;
  logic [OPW-1:0] instr_op;
  logic           instr_op_defined;
  logic [2:0]     exec_alu;

  // Instruction bits between opcode and funct are consumed by the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[15-OPW:FW];

  // DECODE looks at the live instruction register; later states use the
  // opcode captured in DECODE.
  assign instr_op = instr[15 -: OPW];

  always_comb begin
    case (instr_op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_HALT:
        instr_op_defined = 1'b1;
      default:
        instr_op_defined = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode_reg)
      OP_RTYPE: exec_alu = instr[FW-1:0];
      OP_BEQ:   exec_alu = ALU_SUB;
      default:  exec_alu = ALU_ADD;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register and opcode latch
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_FETCH;
      opcode_reg <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (mem_ready) state_reg <= S_DECODE;
        end
        S_DECODE: begin
          opcode_reg <= instr_op;
          if (instr_op == OP_J) begin
            state_reg <= S_FETCH;
          end else if (instr_op == OP_HALT) begin
            state_reg <= S_HALT;
          end else if (instr_op_defined) begin
            state_reg <= S_EXEC;
          end else begin
`ifdef CTRL_TRAP_EN
            state_reg <= S_TRAP;
`else
            state_reg <= S_FETCH;
`endif
          end
        end
        S_EXEC: begin
          case (opcode_reg)
            OP_BEQ:       state_reg <= S_FETCH;
            OP_LW, OP_SW: state_reg <= S_MEM;
            default:      state_reg <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) state_reg <= (opcode_reg == OP_SW) ? S_FETCH : S_WB;
        end
        S_WB:    state_reg <= S_FETCH;
        S_HALT:  state_reg <= S_HALT;
        S_TRAP:  state_reg <= S_TRAP;
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output decode. Reset forces every output low so an aborted instruction
  // cannot write the register file, the PC or memory during the reset cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_iord   = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    pcsrc      = 1'b0;
    jump       = 1'b0;
    memtoreg   = 1'b0;
    alusrc     = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    alucontrol = 3'b000;
    halted     = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          mem_req = 1'b1;
          irwrite = mem_ready;
        end
        S_DECODE: begin
          if (instr_op == OP_J) begin
            jump = 1'b1;
            pcen = 1'b1;
          end
`ifndef CTRL_TRAP_EN
          // Undefined opcode retires here as a NOP.
          if (!instr_op_defined) pcen = 1'b1;
`endif
        end
        S_EXEC: begin
          alucontrol = exec_alu;
          case (opcode_reg)
            OP_BEQ: begin
              pcen  = 1'b1;
              pcsrc = zero;
            end
            OP_LW, OP_SW, OP_ADDI: alusrc = 1'b1;
            default: ;
          endcase
        end
        S_MEM: begin
          // Address and ALU controls held steady for the whole access.
          mem_req    = 1'b1;
          mem_iord   = 1'b1;
          alusrc     = 1'b1;
          alucontrol = ALU_ADD;
          mem_we     = (opcode_reg == OP_SW);
          pcen       = (opcode_reg == OP_SW) && mem_ready;
        end
        S_WB: begin
          regwrite = 1'b1;
          pcen     = 1'b1;
          memtoreg = (opcode_reg == OP_LW);
          regdst   = (opcode_reg == OP_RTYPE);
          alusrc   = (opcode_reg == OP_ADDI);
        end
        S_HALT: begin
          halted = 1'b1;
        end
        S_TRAP: begin
`ifdef CTRL_TRAP_EN
          illegal = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_iord, irwrite, pcen, pcsrc, jump;
  logic        memtoreg, alusrc, regdst, regwrite, halted, illegal;
  logic [2:0]  alucontrol;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_iord(mem_iord), .irwrite(irwrite),
    .pcen(pcen), .pcsrc(pcsrc), .jump(jump), .memtoreg(memtoreg),
    .alusrc(alusrc), .regdst(regdst), .regwrite(regwrite),
    .alucontrol(alucontrol), .halted(halted), .illegal(illegal)
  );

  // Output bundle: {req,we,iord,irw,pcen,pcsrc,jump,m2r,asrc,rdst,rw,alu[2:0],halted,illegal}
  logic [15:0] outs;
  assign outs = {mem_req, mem_we, mem_iord, irwrite, pcen, pcsrc, jump, memtoreg,
                 alusrc, regdst, regwrite, alucontrol, halted, illegal};

  localparam logic [15:0] REQ  = 16'h8000, WE   = 16'h4000, IORD = 16'h2000;
  localparam logic [15:0] IRW  = 16'h1000, PCEN = 16'h0800, PCS  = 16'h0400;
  localparam logic [15:0] JMP  = 16'h0200, M2R  = 16'h0100, ASRC = 16'h0080;
  localparam logic [15:0] RDST = 16'h0040, RW   = 16'h0020, HLT  = 16'h0002;
  localparam logic [15:0] ILL  = 16'h0001;

  typedef struct packed {
    logic        ready;
    logic        z;
    logic [15:0] exp;
  } step_t;

  step_t trace[$];

  function automatic logic [15:0] alu_f(input logic [2:0] a);
    return {11'b0, a, 2'b00};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic defined_op(input logic [3:0] op);
    return (op <= 4'd5) || (op == 4'hF);
  endfunction

  task automatic push(input logic r, input logic z, input logic [15:0] e);
    trace.push_back(step_t'{ready: r, z: z, exp: e});
  endtask

  // Expected per-cycle outputs of one instruction, assembled phase by phase
  // from the instruction's meaning. Phases without a memory request get a
  // random mem_ready, which must be ignored.
  task automatic build_trace(input logic [15:0] ins, input logic zbeq,
                             input int fs, input int ms);
    logic [3:0]  op;
    logic [15:0] mem_o;
    op = ins[15:12];
    trace.delete();
    for (int k = 0; k < fs; k++) push(1'b0, rbit(), REQ);
    push(1'b1, rbit(), REQ | IRW);
    if (op == 4'h5) begin
      push(rbit(), rbit(), PCEN | JMP);
    end else if (op == 4'hF) begin
      push(rbit(), rbit(), 16'h0);
    end else if (!defined_op(op)) begin
`ifdef CTRL_TRAP_EN
      push(rbit(), rbit(), 16'h0);
`else
      push(rbit(), rbit(), PCEN);
`endif
    end else begin
      push(rbit(), rbit(), 16'h0);
      if (op == 4'h3)
        push(rbit(), zbeq, PCEN | alu_f(3'b110) | (zbeq ? PCS : 16'h0));
      else if (op == 4'h0)
        push(rbit(), rbit(), alu_f(ins[2:0]));
      else
        push(rbit(), rbit(), alu_f(3'b010) | ASRC);
      if (op == 4'h1 || op == 4'h2) begin
        mem_o = REQ | IORD | ASRC | alu_f(3'b010) | ((op == 4'h2) ? WE : 16'h0);
        for (int k = 0; k < ms; k++) push(1'b0, rbit(), mem_o);
        push(1'b1, rbit(), mem_o | ((op == 4'h2) ? PCEN : 16'h0));
      end
      if (op != 4'h2 && op != 4'h3)
        push(rbit(), rbit(), RW | PCEN | ((op == 4'h1) ? M2R : 16'h0) |
             ((op == 4'h0) ? RDST : 16'h0) | ((op == 4'h4) ? ASRC : 16'h0));
    end
  endtask

  // Runs one instruction (or its first max_steps cycles when max_steps >= 0).
  task automatic run_instr(input logic [15:0] ins, input logic zbeq, input int fs,
                           input int ms, input int max_steps, input logic retires,
                           input string name);
    int n, pulses, bad;
    build_trace(ins, zbeq, fs, ms);
    n = (max_steps >= 0 && max_steps < trace.size()) ? max_steps : trace.size();
    pulses = 0;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      mem_ready = trace[i].ready;
      zero      = trace[i].z;
      instr     = (i <= fs) ? 16'($urandom) : ins;
      @(negedge clk);
      checks++;
      if (outs !== trace[i].exp) begin
        errors++;
        bad++;
        $display("FAIL %s cycle %0d: outputs %h, required %h", name, i, outs, trace[i].exp);
      end
      if (pcen === 1'b1) pulses++;
      @(posedge clk);
      #1;
    end
    if (retires && n == trace.size()) begin
      checks++;
      if (pulses != 1) begin
        errors++;
        $display("FAIL %s pcen_pulses: saw %0d, required 1", name, pulses);
      end
    end
    $display("txn %-10s instr=%h fstall=%0d mstall=%0d cycles=%0d bad=%0d",
             name, ins, fs, ms, n, bad);
  endtask

  task automatic reset_cycle(input string name);
    reset     = 1'b1;
    mem_ready = 1'b1;
    zero      = rbit();
    instr     = 16'($urandom);
    @(negedge clk);
    checks++;
    if (outs !== 16'h0) begin
      errors++;
      $display("FAIL %s: outputs %h during reset, required 0000", name, outs);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset_cycle("reset_hold1");
    reset_cycle("reset_hold2");
  endtask

  task automatic test_addi();
    run_instr(16'h4100, 1'b0, 0, 0, -1, 1'b1, "addi");
  endtask

  task automatic test_lw_stall();
    run_instr(16'h1a05, 1'b0, 0, 3, -1, 1'b1, "lw_stall");
  endtask

  task automatic test_beq();
    run_instr(16'h3123, 1'b1, 0, 0, -1, 1'b1, "beq_taken");
    run_instr(16'h3123, 1'b0, 1, 0, -1, 1'b1, "beq_not");
  endtask

  task automatic test_j();
    run_instr(16'h5000, 1'b0, 0, 0, -1, 1'b1, "jump");
  endtask

  task automatic test_sw();
    run_instr(16'h2b07, 1'b0, 2, 1, -1, 1'b1, "sw");
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [15:0] ins;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 6))
        0: op = 4'h0;
        1: op = 4'h1;
        2: op = 4'h2;
        3: op = 4'h3;
        4: op = 4'h4;
        5: op = 4'h5;
`ifdef CTRL_TRAP_EN
        default: op = 4'h4;
`else
        default: op = 4'($urandom_range(6, 14));
`endif
      endcase
      ins = {op, 12'($urandom)};
      run_instr(ins, rbit(), $urandom_range(0, 2), $urandom_range(0, 3), -1, 1'b1, "random");
    end
  endtask

  // Reset lands while an LW is stalled in MEM; the next instruction must
  // start from a clean FETCH with no leftover writes.
  task automatic test_reset_mid();
    run_instr(16'h1301, 1'b0, 0, 3, 5, 1'b0, "lw_abort");
    reset_cycle("reset_mid");
    run_instr(16'h0042, 1'b0, 0, 0, -1, 1'b1, "rtype_after");
  endtask

  task automatic terminal_hold(input logic [15:0] want, input string name);
    for (int k = 0; k < 6; k++) begin
      instr     = 16'($urandom);
      mem_ready = rbit();
      zero      = rbit();
      @(negedge clk);
      checks++;
      if (outs !== want) begin
        errors++;
        $display("FAIL %s hold %0d: outputs %h, required %h", name, k, outs, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_illegal();
`ifdef CTRL_TRAP_EN
    run_instr(16'h7000, 1'b0, 0, 0, -1, 1'b0, "illegal");
    terminal_hold(ILL, "trap");
    reset_cycle("reset_trap");
`else
    run_instr(16'h7000, 1'b0, 0, 0, -1, 1'b1, "illegal");
`endif
    run_instr(16'h4321, 1'b0, 0, 0, -1, 1'b1, "addi_post");
  endtask

  task automatic test_halt();
    run_instr(16'hF000, 1'b0, 1, 0, -1, 1'b0, "halt");
    terminal_hold(HLT, "halt");
    reset_cycle("reset_halt");
    run_instr(16'h4100, 1'b0, 0, 0, -1, 1'b1, "addi_final");
  endtask

  initial begin
    reset     = 1'b1;
    instr     = 16'h0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_addi();
    test_lw_stall();
    test_beq();
    test_j();
    test_sw();
    test_random();
    test_reset_mid();
    test_illegal();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
